// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped LED / UART-TX responder.
// Contents:
//   - word offsets (i_Addr[3:2]) of the four registers in the window
//   - bit positions inside the STATUS register
//   - TX serialiser state encoding
package mmio_pkg;

  localparam logic [1:0] REG_LED    = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset (empties FIFO)
//   i_push, i_din[7:0]  write side; a push while full is ignored
//   i_pop, o_dout[7:0]  read side; o_dout is the head entry (combinational)
//   o_full, o_empty     occupancy flags derived from the entry count
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == DEPTH_CNT);
  assign o_empty = (r_count == '0);

  // Flags are taken before this cycle's pop, so a push while full is
  // dropped even if the head leaves in the same cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage has no reset: a cleared count is enough to discard contents.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout = r_mem[r_rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dm_mmio_uart.sv
// Memory-mapped responder on the data-memory bus: 16-bit LED register and
// a byte-wide UART transmitter (8N1, LSB first) behind a small TX FIFO.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_Addr[31:0]   byte address; window is BASE_ADDR..BASE_ADDR+0xF
//   i_Wd[31:0]     write data
//   i_Wen          write enable, acted on at the rising edge when o_Hit=1
//   o_Rd[31:0]     combinational read data (0 outside the window)
//   o_Hit          combinational window match, steers the top-level read mux
//   o_led[15:0]    LED register
//   o_tx           UART serial output, idle high
// Register map (i_Addr[3:2]): 0 LED rw, 1 TXDATA wo, 2 STATUS, 3 reserved.
module dm_mmio_uart
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Wd,
  input  logic        i_Wen,
  output logic [31:0] o_Rd,
  output logic        o_Hit,
  output logic [15:0] o_led,
  output logic        o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    w_off;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic [7:0]    w_fifo_dout;
  logic          w_unused;

  logic [15:0]   r_led;
  logic          r_ovf;
  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  assign o_Hit  = (i_Addr[31:4] == BASE_ADDR[31:4]);
  assign w_off  = i_Addr[3:2];
  assign w_wr   = i_Wen & o_Hit;
  assign w_busy = (r_state != TX_IDLE);

  // Byte lanes [1:0] of the address and the upper write half are don't-care.
  assign w_unused = ^{i_Addr[1:0], i_Wd[31:16]};

  assign w_push = w_wr & (w_off == REG_TXDATA);
  assign w_pop  = (r_state == TX_IDLE) & ~w_empty;

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   (i_Wd[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Register writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_led <= '0;
      r_ovf <= 1'b0;
    end else if (w_wr) begin
      case (w_off)
        REG_LED: r_led <= i_Wd[15:0];
        REG_TXDATA: begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end
        end
        REG_STATUS: begin
          if (i_Wd[STAT_OVF]) begin
            r_ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // TX serialiser. o_tx is registered so that each level is held for exactly
  // CLKS_PER_BIT cycles starting at the edge that enters the bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_fifo_dout;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Read mux
  always_comb begin
    o_Rd = '0;
    if (o_Hit) begin
      case (w_off)
        REG_LED:    o_Rd = {16'b0, r_led};
        REG_STATUS: o_Rd = {28'b0, r_ovf, w_busy, w_full, w_empty};
        default:    o_Rd = '0;
      endcase
    end
  end

  assign o_led = r_led;
  assign o_tx  = r_tx;

endmodule

// File: tb/tb_dm_mmio_uart.sv
module tb_dm_mmio_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic        bus_wen;
  logic [31:0] bus_rd;
  logic        bus_hit;
  logic [15:0] led;
  logic        tx_line;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard of bytes expected on the serial line, in order.
  logic [7:0] sb[$];
  bit         mon_en    = 1'b0;
  bit         b2b_en    = 1'b0;
  bit         have_prev = 1'b0;
  int         prev_start;
  int         mon_start;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;

  dm_mmio_uart #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_Addr (bus_addr),
    .i_Wd   (bus_wd),
    .i_Wen  (bus_wen),
    .o_Rd   (bus_rd),
    .o_Hit  (bus_hit),
    .o_led  (led),
    .o_tx   (tx_line)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Serial monitor: decodes 8N1 frames at CLKS_PER_BIT=4 by sampling on
  // falling clock edges, mid-bit, and checks each byte against the scoreboard.
  always begin
    @(negedge clk);
    if (mon_en && tx_line === 1'b0) begin
      mon_start = cyc;
      if (b2b_en && have_prev) begin
        n_checks++;
        if (mon_start - prev_start !== 41) begin
          n_fail++;
          $display("FAIL frame_spacing: got %0d cycles start-to-start, required 41", mon_start - prev_start);
        end
      end
      prev_start = mon_start;
      have_prev  = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        mon_byte[i] = tx_line;
        if (i < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (tx_line !== 1'b1) begin
        n_fail++;
        $display("FAIL stop_bit: got %b required 1", tx_line);
      end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got byte %h, required no frame", mon_byte);
      end else begin
        mon_exp = sb.pop_front();
        $display("RX  byte=%h expected=%h", mon_byte, mon_exp);
        if (mon_byte !== mon_exp) begin
          n_fail++;
          $display("FAIL rx_byte: got %h required %h", mon_byte, mon_exp);
        end
      end
      repeat (2) @(negedge clk);
    end
  end

  // Drive one bus write; the write lands at the next rising edge and the
  // task returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a;
    bus_wd   = d;
    bus_wen  = 1'b1;
    @(posedge clk);
    #1;
    bus_wen = 1'b0;
    $display("WR  addr=%h data=%h", a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    bus_addr = a;
    #1;
    v = bus_rd;
    $display("RD  addr=%h data=%h hit=%b", a, v, bus_hit);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    n_checks++;
    if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h required 0000", led); end
    n_checks++;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx_line); end
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h required 00000001", v); end

    // 0x55 starts a frame, 0x66 stays queued; reset lands inside data bit 1 (a 0).
    wr(32'h1004, 32'h55);
    wr(32'h1004, 32'h66);
    repeat (9) @(posedge clk);
    #1;
    rd_reg(32'h1008, v);
    n_checks++;
    if (v[2] !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b required 1", v[2]); end
    n_checks++;
    if (tx_line !== 1'b0) begin n_fail++; $display("FAIL midframe_tx: got %b required 0", tx_line); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b required 1", tx_line); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL post_reset_status: got %h required 00000001", v); end
    repeat (3) @(posedge clk);
    #1;
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL fifo_discarded: got %h required 00000001", v); end
    n_checks++;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after_reset: got %b required 1", tx_line); end
  endtask

  task automatic test_led();
    logic [31:0] v;
    wr(32'h1000, 32'hDEAD_BEEF);
    n_checks++;
    if (led !== 16'hBEEF) begin n_fail++; $display("FAIL led_out: got %h required beef", led); end
    rd_reg(32'h1000, v);
    n_checks++;
    if (v !== 32'h0000_BEEF) begin n_fail++; $display("FAIL led_read: got %h required 0000beef", v); end
    n_checks++;
    if (bus_hit !== 1'b1) begin n_fail++; $display("FAIL hit_in_window: got %b required 1", bus_hit); end
    rd_reg(32'h1003, v);
    n_checks++;
    if (v !== 32'h0000_BEEF) begin n_fail++; $display("FAIL led_read_bytelane: got %h required 0000beef", v); end
    rd_reg(32'h2000, v);
    n_checks++;
    if (bus_hit !== 1'b0) begin n_fail++; $display("FAIL hit_outside: got %b required 0", bus_hit); end
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rd_outside: got %h required 00000000", v); end
    wr(32'h2000, 32'h1234_5678);
    n_checks++;
    if (led !== 16'hBEEF) begin n_fail++; $display("FAIL led_write_outside: got %h required beef", led); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] v;
    logic [9:0]  frame;
    logic        exp_bit;
    int          waited;
    frame  = {1'b1, 8'hA5, 1'b0};
    mon_en = 1'b1;
    sb.push_back(8'hA5);
    wr(32'h1004, 32'hA5);
    n_checks++;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL tx_before_start: got %b required 1", tx_line); end
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      exp_bit = frame[(j-1)/4];
      n_checks++;
      if (tx_line !== exp_bit) begin
        n_fail++;
        $display("FAIL tx_bit_cycle%0d: got %b required %b", j, tx_line, exp_bit);
      end
      if (j == 20) begin
        rd_reg(32'h1008, v);
        n_checks++;
        if (v[2] !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b required 1", v[2]); end
      end
    end
    @(posedge clk);
    #1;
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL status_after_frame: got %h required 00000001", v); end
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL frame_drain: got %0d pending bytes required 0", sb.size()); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] v;
    int          waited;
    have_prev = 1'b0;
    b2b_en    = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      wr(32'h1004, 32'(i));
    end
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h6) begin n_fail++; $display("FAIL status_full: got %h required 00000006", v); end
    wr(32'h1004, 32'h06);
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'hE) begin n_fail++; $display("FAIL status_overflow: got %h required 0000000e", v); end
    waited = 0;
    while (sb.size() != 0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending bytes required 0", sb.size()); end
    repeat (8) @(posedge clk);
    #1;
    b2b_en = 1'b0;
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL status_after_b2b: got %h required 00000009", v); end
  endtask

  task automatic test_overflow_clear();
    logic [31:0] v;
    wr(32'h1008, 32'h0);
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL ovf_keep_on_zero: got %h required 00000009", v); end
    wr(32'h1008, 32'h8);
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h required 00000001", v); end
    wr(32'h1008, 32'hFFFF_FFF7);
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL status_other_bits: got %h required 00000001", v); end
  endtask

  task automatic test_reserved_and_wen();
    logic [31:0] v;
    wr(32'h100C, 32'hFFFF_FFFF);
    rd_reg(32'h100C, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rsvd_read: got %h required 00000000", v); end
    n_checks++;
    if (bus_hit !== 1'b1) begin n_fail++; $display("FAIL rsvd_hit: got %b required 1", bus_hit); end
    n_checks++;
    if (led !== 16'hBEEF) begin n_fail++; $display("FAIL rsvd_led: got %h required beef", led); end
    rd_reg(32'h1004, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h required 00000000", v); end
    bus_addr = 32'h1004;
    bus_wd   = 32'h77;
    bus_wen  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (tx_line !== 1'b1) begin n_fail++; $display("FAIL wen_low_tx: got %b required 1", tx_line); end
    rd_reg(32'h1008, v);
    n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL wen_low_status: got %h required 00000001", v); end
  endtask

  initial begin
    rst      = 1'b1;
    bus_addr = 32'h0;
    bus_wd   = 32'h0;
    bus_wen  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset_midframe();
    test_led();
    test_tx_frame();
    test_fifo_full();
    test_overflow_clear();
    test_reserved_and_wen();
    repeat (50) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d pending bytes required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
